// File: rtl/mult_unit_pkg.sv
// Shared encodings and types for the iterative multiplier.
// Holds the ALU1 control codes, default width and FSM states.
package mult_unit_pkg;

   localparam int MULT_WIDTH = 32;

   typedef enum logic [3:0] {
      ALU1_AND  = 4'b0000,
      ALU1_OR   = 4'b0001,
      ALU1_ADD  = 4'b0010,
      ALU1_SUB  = 4'b0110,
      ALU1_SLT  = 4'b0111,
      ALU1_XOR  = 4'b1000,
      ALU1_MULT = 4'b1100,
      ALU1_NOR  = 4'b1101
   } alu1_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      SIGN = 2'd2
   } mult_state_e;

endpackage

// File: rtl/mult_shift_add.sv
// Shift-add datapath: accumulator, WIDTH+1-bit adder and shift.
// Operates on unsigned magnitudes; sign handling lives in the top.
module mult_shift_add
   import mult_unit_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               step,
   input  logic [WIDTH-1:0]   mcand_in,
   input  logic [WIDTH-1:0]   mplier_in,
   output logic [2*WIDTH-1:0] prod
);

   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] acc_hi;
   logic [WIDTH-1:0] acc_lo;
   logic [WIDTH:0]   sum;

   // The carry out of the add becomes the new top bit after the shift.
   assign sum = {1'b0, acc_hi}
              + (acc_lo[0] ? {1'b0, mcand} : '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mcand  <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
      end else if (load) begin
         mcand  <= mcand_in;
         acc_hi <= '0;
         acc_lo <= mplier_in;
      end else if (step) begin
         acc_hi <= sum[WIDTH:1];
         acc_lo <= {sum[0], acc_lo[WIDTH-1:1]};
      end
   end

   assign prod = {acc_hi, acc_lo};

endmodule

// File: rtl/mult_unit.sv
// Iterative mult/multu unit: FSM, counter, sign fix-up, hi/lo.
// Fixed WIDTH+2 cycle latency regardless of operand values.
module mult_unit
   import mult_unit_pkg::*;
#(
   parameter int         WIDTH   = MULT_WIDTH,
   parameter logic [3:0] MULT_OP = ALU1_MULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       alu1_control,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   mult_state_e        state;
   logic [CW-1:0]      cnt;
   logic               signed_r;
   logic               xor_r;
   logic               rsign;
   logic               accept;
   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] result;

   assign accept = (state == IDLE) && start
                && (alu1_control == MULT_OP);

   assign a_neg = signed_op & op_a[WIDTH-1];
   assign b_neg = signed_op & op_b[WIDTH-1];
   assign a_mag = a_neg ? -op_a : op_a;
   assign b_mag = b_neg ? -op_b : op_b;

   // The most-negative value maps onto itself, read as unsigned.
   assign rsign  = signed_r & xor_r;
   assign result = rsign ? -prod : prod;

   mult_shift_add #(
      .WIDTH(WIDTH)
   ) u_dp (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (accept),
      .step     (state == RUN),
      .mcand_in (a_mag),
      .mplier_in(b_mag),
      .prod     (prod)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         signed_r <= 1'b0;
         xor_r    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (accept) begin
                  state    <= RUN;
                  cnt      <= '0;
                  busy     <= 1'b1;
                  signed_r <= signed_op;
                  xor_r    <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
               end
            end
            RUN: begin
               if (cnt == LAST) begin
                  state <= SIGN;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            SIGN: begin
               state    <= IDLE;
               busy     <= 1'b0;
               done     <= 1'b1;
               {hi, lo} <= result;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_unit.sv
// Directed plus random checks of mult_unit against a
// plain-arithmetic 64-bit product model.
module tb_mult_unit;
   import mult_unit_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [3:0]  alu1_control;
   logic        signed_op;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int          errors;
   int          checks;
   logic [63:0] prev;
   int          n;
   bit          saw_done;

   mult_unit #(
      .WIDTH  (32),
      .MULT_OP(4'b1100)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .alu1_control(alu1_control),
      .signed_op   (signed_op),
      .op_a        (op_a),
      .op_b        (op_b),
      .busy        (busy),
      .done        (done),
      .hi          (hi),
      .lo          (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] model(
      input logic [31:0] a,
      input logic [31:0] b,
      input bit          s
   );
      longint sa;
      longint sb;
      logic [63:0] ua;
      logic [63:0] ub;
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         return 64'(sa * sb);
      end
      ua = {32'd0, a};
      ub = {32'd0, b};
      return ua * ub;
   endfunction

   task automatic chk(
      input string       tag,
      input logic [63:0] obs,
      input logic [63:0] exp
   );
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive a request now; it is taken at the next rising edge.
   task automatic issue(
      input logic [31:0] a,
      input logic [31:0] b,
      input bit          s
   );
      start        = 1'b1;
      alu1_control = 4'b1100;
      op_a         = a;
      op_b         = b;
      signed_op    = s;
      @(posedge clk);
      #1;
      start     = 1'b0;
      op_a      = $urandom;
      op_b      = $urandom;
      signed_op = 1'($urandom);
   endtask

   // Wait for done; poke>0 re-asserts start at that run cycle.
   task automatic wait_done(
      input string       tag,
      input logic [63:0] exp,
      input int          poke
   );
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
         if (n == 5) begin
            chk({tag, "_hold"}, {hi, lo}, prev);
            chk({tag, "_busy"}, 64'(busy), 64'd1);
         end
         if (poke > 0 && n == poke) begin
            start        = 1'b1;
            alu1_control = 4'b1100;
            op_a         = $urandom;
            op_b         = $urandom;
         end
         if (poke > 0 && n == poke + 1) start = 1'b0;
      end while (!done && n < 40);
      chk({tag, "_lat"}, 64'(n), 64'd33);
      chk({tag, "_res"}, {hi, lo}, exp);
      chk({tag, "_idle"}, 64'(busy), 64'd0);
      prev = exp;
   endtask

   initial begin
      errors       = 0;
      checks       = 0;
      prev         = '0;
      rst_n        = 1'b0;
      start        = 1'b0;
      alu1_control = 4'b0000;
      signed_op    = 1'b0;
      op_a         = '0;
      op_b         = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_hilo", {hi, lo}, 64'd0);
      rst_n = 1'b1;

      issue(32'd3, 32'd5, 1'b1);
      wait_done("s3x5", 64'h00000000_0000000F, 0);
      chk("s3x5_model", {hi, lo}, model(32'd3, 32'd5, 1'b1));

      issue(32'hFFFFFFFE, 32'd3, 1'b1);
      wait_done("sm2x3", 64'hFFFFFFFF_FFFFFFFA, 0);

      issue(32'h80000000, 32'h80000000, 1'b1);
      wait_done("smin2", 64'h40000000_00000000, 0);

      issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
      wait_done("umax2", 64'hFFFFFFFE_00000001, 0);

      start        = 1'b1;
      alu1_control = 4'b0010;
      op_a         = 32'd9;
      op_b         = 32'd9;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("nop_busy", 64'(busy), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("nop_busy2", 64'(busy), 64'd0);
      chk("nop_hilo", {hi, lo}, prev);

      issue(32'h12345678, 32'hFEDCBA98, 1'b1);
      wait_done("poke", model(32'h12345678, 32'hFEDCBA98, 1'b1), 10);

      issue(32'hDEADBEEF, 32'h00C0FFEE, 1'b0);
      repeat (15) @(posedge clk);
      #1;
      rst_n        = 1'b0;
      start        = 1'b1;
      alu1_control = 4'b1100;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      start = 1'b0;
      chk("mid_rst_hilo", {hi, lo}, 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      prev     = '0;
      saw_done = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done) saw_done = 1'b1;
      end
      chk("mid_rst_nodone", 64'(saw_done), 64'd0);
      chk("mid_rst_hold", {hi, lo}, 64'd0);

      issue(32'd7, 32'd6, 1'b1);
      wait_done("s7x6", 64'h00000000_0000002A, 0);

      issue(32'hFFFFFFF9, 32'd6, 1'b1);
      wait_done("b2b_a", model(32'hFFFFFFF9, 32'd6, 1'b1), 0);
      issue(32'h0000FFFF, 32'h00010001, 1'b0);
      wait_done("b2b_b", 64'h00000000_FFFFFFFF, 0);

      for (int i = 0; i < 6; i++) begin
         logic [31:0] ra;
         logic [31:0] rb;
         bit          rs;
         ra = $urandom;
         rb = $urandom;
         rs = 1'($urandom);
         issue(ra, rb, rs);
         wait_done($sformatf("rnd%0d", i), model(ra, rb, rs), 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
